// File: rtl/shift_pkg.sv
// Shared types and sizes for the shift arbiter controller and its shift core.
package shift_pkg;

    localparam int SHIFT_WIDTH = 16;
    localparam int SHIFT_CNT_W = 4;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational 16-bit shifter: SLL / SRL / SRA / ROL.
// Rotate logic exists only when SHIFT_ARB_ROTATE_EN is defined; otherwise ROL passes the operand and flags err.
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] cnt,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] out_data,
    output logic             err
);

`ifdef SHIFT_ARB_ROTATE_EN
    logic [2*WIDTH-1:0] rot_full;
    assign rot_full = {in_data, in_data} << cnt;
`endif

    always_comb begin
        out_data = in_data;
        err      = 1'b0;
        case (op)
            SLL: out_data = in_data << cnt;
            SRL: out_data = in_data >> cnt;
            SRA: out_data = $signed(in_data) >>> cnt;
`ifdef SHIFT_ARB_ROTATE_EN
            ROL: out_data = rot_full[2*WIDTH-1:WIDTH];
`else
            ROL: err = 1'b1;
`endif
            default: out_data = in_data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter sharing one shift_core between two requesters, with a one-entry tagged result buffer.
// Optional rotate support: define SHIFT_ARB_ROTATE_EN.
module shift_arbiter_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in,
    input  logic [CNT_W-1:0] req1_cnt,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err
);

    arb_state_e       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             res_err_q, res_err_d;

    logic             win_sel;
    logic             grant;
    logic [WIDTH-1:0] sel_in;
    logic [CNT_W-1:0] sel_cnt;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] core_out;
    logic             core_err;

    shift_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .in_data  (sel_in),
        .cnt      (sel_cnt),
        .op       (shift_op_e'(sel_op)),
        .out_data (core_out),
        .err      (core_err)
    );

    always_comb begin
        // With a single valid requester it wins; rr_ptr only breaks ties.
        win_sel = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
        grant   = (req0_valid || req1_valid) && ((state_q == EMPTY) || res_ready) && !rst;

        sel_in  = win_sel ? req1_in  : req0_in;
        sel_cnt = win_sel ? req1_cnt : req0_cnt;
        sel_op  = win_sel ? req1_op  : req0_op;

        req0_ready = grant && !win_sel;
        req1_ready = grant && win_sel;

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_err_d  = res_err_q;

        if (grant) begin
            state_d    = FULL;
            rr_ptr_d   = !win_sel;
            res_data_d = core_out;
            res_id_d   = win_sel;
            res_err_d  = core_err;
        end else if (res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;

endmodule
